svm_ctrl_regs: RTL and testbench

- Parametrised multi-channel control/status register block between the AXI-Lite slave decode and NUM_CH SVM/deskew engines.
- Per channel it provides:
  - a one-cycle start pulse, gated by the channel's ready status;
  - a busy-tracking FSM;
  - a sticky, maskable done interrupt with write-1-to-clear;
  - a sticky start-rejected error flag.
- All per-channel interrupts combine into one registered irq_o toward the AXI interrupt line.

---
 rtl/svm_ctrl_pkg.sv | 21 ++
 rtl/svm_ch_ctrl.sv | 79 +++++++
 rtl/svm_ctrl_regs.sv | 132 +++++++++++++
 tb/tb_svm_ctrl_regs.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_ctrl_pkg.sv
// Shared definitions for the SVM/deskew control register block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package svm_ctrl_pkg;

   // Word addresses of the register map
   localparam int unsigned ADDR_CMD    = 0;
   localparam int unsigned ADDR_STATUS = 1;
   localparam int unsigned ADDR_BUSY   = 2;
   localparam int unsigned ADDR_PEND   = 3;
   localparam int unsigned ADDR_EN     = 4;
   localparam int unsigned ADDR_ERR    = 5;

   // Per-channel engine sequencing state
   typedef enum logic [1:0] {
      CH_IDLE  = 2'd0,
      CH_START = 2'd1,
      CH_BUSY  = 2'd2
   } ch_state_e;

endpackage

// File: rtl/svm_ch_ctrl.sv
// One engine channel: start/busy FSM plus sticky done-pending and start-error bits.
// Latency: start_o high the cycle after an accepted request; sticky bits update on the next edge.
// Backpressure: none; a request while not idle or not ready is dropped and flagged in err_o.
module svm_ch_ctrl
   import svm_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic cmd_req,
   input  logic ready,
   input  logic done_rise,
   input  logic pend_clr,
   input  logic err_clr,
   output logic start_o,
   output logic busy_o,
   output logic pend_o,
   output logic err_o
);

   ch_state_e state;
   ch_state_e state_nxt;
   logic      err_set;

   // State register; synchronous reset aborts any start in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= CH_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, start pulse and rejected-request detection
   always_comb begin
      state_nxt = state;
      start_o   = 1'b0;
      err_set   = 1'b0;
      case (state)
         CH_IDLE: begin
            if (cmd_req) begin
               if (ready) begin
                  state_nxt = CH_START;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         CH_START: begin
            start_o   = 1'b1;
            err_set   = cmd_req;
            // an engine may finish within its first cycle
            state_nxt = done_rise ? CH_IDLE : CH_BUSY;
         end
         CH_BUSY: begin
            err_set = cmd_req;
            if (done_rise) begin
               state_nxt = CH_IDLE;
            end
         end
         default: begin
            state_nxt = CH_IDLE;
         end
      endcase
   end

   // Sticky flags: a new event wins over a simultaneous write-1-to-clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_o <= 1'b0;
         err_o  <= 1'b0;
      end else begin
         pend_o <= done_rise | (pend_o & ~pend_clr);
         err_o  <= err_set | (err_o & ~err_clr);
      end
   end

   assign busy_o = (state != CH_IDLE);

endmodule

// File: rtl/svm_ctrl_regs.sv
// Control/status registers for NUM_CH SVM/deskew engines with combined interrupt.
// Latency: reads 1 cycle; done input to pend 2 cycles, to irq_o 3 cycles.
// Backpressure: none; every strobe is accepted the cycle it is presented.
module svm_ctrl_regs
   import svm_ctrl_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   output logic [NUM_CH-1:0] start_o,
   input  logic [NUM_CH-1:0] ready_i,
   input  logic [NUM_CH-1:0] done_intr_i,
   output logic              irq_o
);

   localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(ADDR_CMD);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(ADDR_STATUS);
   localparam logic [ADDR_W-1:0] A_BUSY   = ADDR_W'(ADDR_BUSY);
   localparam logic [ADDR_W-1:0] A_PEND   = ADDR_W'(ADDR_PEND);
   localparam logic [ADDR_W-1:0] A_EN     = ADDR_W'(ADDR_EN);
   localparam logic [ADDR_W-1:0] A_ERR    = ADDR_W'(ADDR_ERR);

   logic [NUM_CH-1:0] ready_q;
   logic [NUM_CH-1:0] done_q;
   logic [NUM_CH-1:0] done_q_d;
   logic [NUM_CH-1:0] done_rise;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] err;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] wr_bits;
   logic [NUM_CH-1:0] cmd_req;
   logic [NUM_CH-1:0] pend_clr;
   logic [NUM_CH-1:0] err_clr;
   logic [DATA_W-1:0] rd_word;

   // Register map only implements the low NUM_CH bits of each word
   if (NUM_CH < DATA_W) begin : g_wr_hi
      logic unused_wr_hi;
      assign unused_wr_hi = ^wr_data_i[DATA_W-1:NUM_CH];
   end

   assign wr_bits   = wr_data_i[NUM_CH-1:0];
   assign cmd_req   = (wr_en_i && wr_addr_i == A_CMD)  ? wr_bits : '0;
   assign pend_clr  = (wr_en_i && wr_addr_i == A_PEND) ? wr_bits : '0;
   assign err_clr   = (wr_en_i && wr_addr_i == A_ERR)  ? wr_bits : '0;
   assign done_rise = done_q & ~done_q_d;

   // Engine-side inputs registered once; done delayed again for edge detection
   always_ff @(posedge clk) begin
      if (!reset) begin
         ready_q  <= '0;
         done_q   <= '0;
         done_q_d <= '0;
      end else begin
         ready_q  <= ready_i;
         done_q   <= done_intr_i;
         done_q_d <= done_q;
      end
   end

   // Interrupt enable mask
   always_ff @(posedge clk) begin
      if (!reset) begin
         en <= '0;
      end else if (wr_en_i && wr_addr_i == A_EN) begin
         en <= wr_bits;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      svm_ch_ctrl u_ch (
         .clk       (clk),
         .reset     (reset),
         .cmd_req   (cmd_req[i]),
         .ready     (ready_q[i]),
         .done_rise (done_rise[i]),
         .pend_clr  (pend_clr[i]),
         .err_clr   (err_clr[i]),
         .start_o   (start_o[i]),
         .busy_o    (busy[i]),
         .pend_o    (pend[i]),
         .err_o     (err[i])
      );
   end

   // Read mux over current state, so a same-cycle write is seen on the next read
   always_comb begin
      rd_word = '0;
      case (rd_addr_i)
         A_STATUS: rd_word[NUM_CH-1:0] = ready_q;
         A_BUSY:   rd_word[NUM_CH-1:0] = busy;
         A_PEND:   rd_word[NUM_CH-1:0] = pend;
         A_EN:     rd_word[NUM_CH-1:0] = en;
         A_ERR:    rd_word[NUM_CH-1:0] = err;
         default:  rd_word = '0;
      endcase
   end

   // Registered read data holds between reads
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_data_o  <= '0;
         rd_valid_o <= 1'b0;
      end else begin
         rd_valid_o <= rd_en_i;
         if (rd_en_i) begin
            rd_data_o <= rd_word;
         end
      end
   end

   // Combined interrupt toward the bus interrupt line
   always_ff @(posedge clk) begin
      if (!reset) begin
         irq_o <= 1'b0;
      end else begin
         irq_o <= |(pend & en);
      end
   end

endmodule

// File: tb/tb_svm_ctrl_regs.sv
// Self-checking bench for svm_ctrl_regs: start table, interrupt and corner sequences.
// Reads are scoreboarded: expected data queued at request, compared when rd_valid_o rises.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_svm_ctrl_regs;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 3;

   logic              clk;
   logic              reset;
   logic              wr_en_i;
   logic [ADDR_W-1:0] wr_addr_i;
   logic [DATA_W-1:0] wr_data_i;
   logic              rd_en_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic [DATA_W-1:0] rd_data_o;
   logic              rd_valid_o;
   logic [NUM_CH-1:0] start_o;
   logic [NUM_CH-1:0] ready_i;
   logic [NUM_CH-1:0] done_intr_i;
   logic              irq_o;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];
   logic [31:0] mon_exp;
   string       mon_name;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] exp;
   } rd_vec_t;

   typedef struct {
      logic [3:0] ready;
      logic [3:0] cmd;
      logic [3:0] exp_start;
      logic [3:0] exp_err;
   } st_vec_t;

   rd_vec_t rv[8];
   st_vec_t sv[4];

   svm_ctrl_regs #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en_i     (wr_en_i),
      .wr_addr_i   (wr_addr_i),
      .wr_data_i   (wr_data_i),
      .rd_en_i     (rd_en_i),
      .rd_addr_i   (rd_addr_i),
      .rd_data_o   (rd_data_o),
      .rd_valid_o  (rd_valid_o),
      .start_o     (start_o),
      .ready_i     (ready_i),
      .done_intr_i (done_intr_i),
      .irq_o       (irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_write(input logic [2:0] addr, input logic [31:0] data);
      wr_en_i   = 1'b1;
      wr_addr_i = addr;
      wr_data_i = data;
      tick();
      wr_en_i   = 1'b0;
      wr_data_i = '0;
   endtask

   task automatic do_read(input logic [2:0] addr, input logic [31:0] exp, input string nm);
      rd_en_i   = 1'b1;
      rd_addr_i = addr;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      tick();
      rd_en_i = 1'b0;
   endtask

   task automatic apply_reset();
      reset       = 1'b0;
      wr_en_i     = 1'b0;
      rd_en_i     = 1'b0;
      ready_i     = '0;
      done_intr_i = '0;
      tick(3);
      reset = 1'b1;
   endtask

   // Read scoreboard: every rd_valid_o must match the oldest outstanding read
   always @(negedge clk) begin
      if (rd_valid_o) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rd_valid: got data %0h with no read outstanding", rd_data_o);
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            chk(mon_name, rd_data_o, mon_exp);
         end
      end
   end

   initial begin
      reset       = 1'b0;
      wr_en_i     = 1'b0;
      wr_addr_i   = '0;
      wr_data_i   = '0;
      rd_en_i     = 1'b0;
      rd_addr_i   = '0;
      ready_i     = '0;
      done_intr_i = '0;

      for (int i = 0; i < 8; i++) begin
         rv[i].addr = 3'(i);
         rv[i].exp  = 32'h0;
      end
      sv[0] = '{4'b0101, 4'b0001, 4'b0001, 4'b0000};
      sv[1] = '{4'b0000, 4'b0010, 4'b0000, 4'b0010};
      sv[2] = '{4'b0101, 4'b1111, 4'b0101, 4'b1010};
      sv[3] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};

      @(negedge clk);

      // Reset defaults over the whole map
      apply_reset();
      chk("rst_start", 32'(start_o), 32'h0);
      chk("rst_irq", 32'(irq_o), 32'h0);
      for (int i = 0; i < 8; i++) begin
         do_read(rv[i].addr, rv[i].exp, $sformatf("rst_rd_addr%0d", i));
      end

      // Start acceptance / rejection table
      for (int k = 0; k < 4; k++) begin
         apply_reset();
         ready_i = sv[k].ready;
         tick(2);
         do_write(3'd0, 32'(sv[k].cmd));
         chk($sformatf("v%0d_start_pulse", k), 32'(start_o), 32'(sv[k].exp_start));
         tick();
         chk($sformatf("v%0d_start_one_cycle", k), 32'(start_o), 32'h0);
         do_read(3'd2, 32'(sv[k].exp_start), $sformatf("v%0d_busy", k));
         do_read(3'd5, 32'(sv[k].exp_err), $sformatf("v%0d_err", k));
         do_write(3'd5, 32'hFFFF_FFFF);
         do_read(3'd5, 32'h0, $sformatf("v%0d_err_w1c", k));
      end

      // Done interrupt path, level-held done, W1C pend
      apply_reset();
      ready_i = 4'b0001;
      tick(2);
      do_write(3'd4, 32'h1);
      do_write(3'd0, 32'h1);
      done_intr_i = 4'b0001;
      tick();
      chk("irq_after_e", 32'(irq_o), 32'h0);
      tick();
      chk("irq_after_e1", 32'(irq_o), 32'h0);
      tick();
      chk("irq_after_e2", 32'(irq_o), 32'h1);
      do_read(3'd3, 32'h1, "pend_set");
      do_read(3'd2, 32'h0, "busy_after_done");
      do_write(3'd3, 32'h1);
      chk("irq_before_clr", 32'(irq_o), 32'h1);
      tick();
      chk("irq_after_clr", 32'(irq_o), 32'h0);
      do_read(3'd3, 32'h0, "pend_level_once");
      done_intr_i = '0;
      tick(2);

      // Done edge coincides with W1C on channel 2
      apply_reset();
      ready_i = 4'b0100;
      tick(2);
      do_write(3'd0, 32'h4);
      done_intr_i = 4'b0100;
      tick();
      do_write(3'd3, 32'h4);
      done_intr_i = '0;
      do_read(3'd3, 32'h4, "pend_set_wins");
      do_read(3'd2, 32'h0, "ch2_idle");

      // Masked interrupt, restart while busy, reset mid-busy
      apply_reset();
      ready_i = 4'b0010;
      tick(2);
      do_write(3'd0, 32'h2);
      tick(2);
      do_write(3'd0, 32'h2);
      chk("no_restart_pulse", 32'(start_o), 32'h0);
      tick();
      chk("no_restart_pulse2", 32'(start_o), 32'h0);
      do_read(3'd5, 32'h2, "err_restart_busy");
      do_read(3'd2, 32'h2, "still_busy");
      done_intr_i = 4'b0010;
      tick();
      done_intr_i = '0;
      tick(3);
      do_read(3'd3, 32'h2, "pend_masked");
      chk("irq_masked", 32'(irq_o), 32'h0);
      do_read(3'd2, 32'h0, "idle_after_done1");
      do_write(3'd0, 32'h2);
      tick(2);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rst_mid_start", 32'(start_o), 32'h0);
      do_read(3'd2, 32'h0, "busy_after_rst");
      do_read(3'd3, 32'h0, "pend_after_rst");

      // Unused addresses, high bits, read-before-write, status
      apply_reset();
      do_write(3'd6, 32'hFFFF_FFFF);
      do_read(3'd6, 32'h0, "addr6_ignored");
      do_write(3'd4, 32'hFFFF_FFFF);
      do_read(3'd4, 32'hF, "en_high_bits");
      wr_en_i   = 1'b1;
      wr_addr_i = 3'd4;
      wr_data_i = 32'h3;
      rd_en_i   = 1'b1;
      rd_addr_i = 3'd4;
      exp_q.push_back(32'hF);
      name_q.push_back("rd_pre_write");
      tick();
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      do_read(3'd4, 32'h3, "en_post_write");
      ready_i = 4'b1010;
      tick(2);
      do_read(3'd1, 32'hA, "status");

      tick(3);
      chk("rd_queue_empty", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
